sha256_round_ctrl: RTL and testbench

SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

---
 rtl/sha256_round_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sha256_round_ctrl
//
// Sequencer for an iterative SHA-256 compression core. For each 512-bit
// block it loads the working registers a..h from the intermediate hash H
// (or the IV for the first block). It then steps the 64 rounds, and finally
// pulses the H += a..h accumulate. After the last block it pulses done.
//
// Ports
//   clk         system clock, rising-edge state updates
//   rst_n       asynchronous active-low reset
//   start       hash request, honoured only while idle
//   abort       synchronous cancel, honoured in every non-idle state
//   num_blocks  block count latched on start (0 behaves as 1)
//   load_init   1 = working registers load from H, 0 = shift datapath
//   iv_sel      1 = H register file presents the SHA-256 IV
//   round_idx   current round t, indexes K ROM and W schedule
//   w_sel       0 = W_t from message word, 1 = W_t from expanded schedule
//   add_en      one-cycle strobe for H_i += working register i
//   block_idx   index of the block being processed
//   busy        high in every state except IDLE
//   done        one-cycle pulse when the final H is valid
//
// State table
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start, all outputs low
//   S_INIT  | one cycle, working registers load from H / IV
//   S_ROUND | 64 cycles, round_idx 0..63
//   S_FINAL | one cycle, add_en strobe, choose next block or finish
//   S_DONE  | one cycle, done pulse
//
// Every output is a flop. The next-state logic also computes the output
// values for the state being entered, so the outputs change on the same
// edge as the state. No input reaches an output without passing a flop.
// ---------------------------------------------------------------------------
module sha256_round_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] num_blocks,
    output logic       load_init,
    output logic       iv_sel,
    output logic [5:0] round_idx,
    output logic       w_sel,
    output logic       add_en,
    output logic [1:0] block_idx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [5:0] LAST_ROUND   = 6'd63;
    localparam logic [5:0] FIRST_SCHED  = 6'd16;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic [5:0] round_d;
    logic [1:0] block_d;
    logic       load_init_d;
    logic       iv_sel_d;
    logic       w_sel_d;
    logic       add_en_d;
    logic       busy_d;
    logic       done_d;
    logic       more_blocks;

    // Widened by one bit so that block_idx + 1 cannot overflow before the compare.
    assign more_blocks = (({1'b0, block_idx} + 3'd1) < {1'b0, count_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= 2'd1;
            round_idx <= 6'd0;
            block_idx <= 2'd0;
            load_init <= 1'b0;
            iv_sel    <= 1'b0;
            w_sel     <= 1'b0;
            add_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            round_idx <= round_d;
            block_idx <= block_d;
            load_init <= load_init_d;
            iv_sel    <= iv_sel_d;
            w_sel     <= w_sel_d;
            add_en    <= add_en_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        round_d = round_idx;
        block_d = block_idx;

        if (abort && (state_q != S_IDLE)) begin
            // Cancel wins over every transition, including the FINAL and DONE exits.
            state_d = S_IDLE;
            round_d = 6'd0;
            block_d = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    round_d = 6'd0;
                    block_d = 2'd0;
                    if (start && !abort) begin
                        state_d = S_INIT;
                        count_d = (num_blocks == 2'd0) ? 2'd1 : num_blocks;
                    end
                end
                S_INIT: begin
                    state_d = S_ROUND;
                    round_d = 6'd0;
                end
                S_ROUND: begin
                    // The increment is gated at 63, so round_idx holds there and never wraps.
                    if (round_idx == LAST_ROUND) begin
                        state_d = S_FINAL;
                    end else begin
                        round_d = round_idx + 6'd1;
                    end
                end
                S_FINAL: begin
                    if (more_blocks) begin
                        state_d = S_INIT;
                        block_d = block_idx + 2'd1;
                        round_d = 6'd0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    round_d = 6'd0;
                    block_d = 2'd0;
                end
                default: begin
                    state_d = S_IDLE;
                    round_d = 6'd0;
                    block_d = 2'd0;
                end
            endcase
        end
    end

    // Output values for the state being entered; registered alongside state_q.
    always_comb begin
        load_init_d = 1'b0;
        iv_sel_d    = 1'b0;
        w_sel_d     = 1'b0;
        add_en_d    = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            S_INIT: begin
                load_init_d = 1'b1;
                iv_sel_d    = (block_d == 2'd0);
                busy_d      = 1'b1;
            end
            S_ROUND: begin
                w_sel_d = (round_d >= FIRST_SCHED);
                busy_d  = 1'b1;
            end
            S_FINAL: begin
                add_en_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
`timescale 1ns/1ps
module tb_sha256_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] num_blocks = 2'd0;
    logic       load_init;
    logic       iv_sel;
    logic [5:0] round_idx;
    logic       w_sel;
    logic       add_en;
    logic [1:0] block_idx;
    logic       busy;
    logic       done;

    sha256_round_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .num_blocks (num_blocks),
        .load_init  (load_init),
        .iv_sel     (iv_sel),
        .round_idx  (round_idx),
        .w_sel      (w_sel),
        .add_en     (add_en),
        .block_idx  (block_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       load_init;
        logic       iv_sel;
        logic [5:0] round;
        logic       w_sel;
        logic       add_en;
        logic [1:0] blk;
        logic       busy;
        logic       done;
    } exp_t;

    wire [13:0] dut_vec = {load_init, iv_sel, round_idx, w_sel, add_en, block_idx, busy, done};

    int total = 0;
    int bad = 0;

    // Reference model: on acceptance, the whole expected output timeline of a
    // hash is written out cycle by cycle into a queue, then replayed.
    exp_t q[$];
    exp_t cur = '0;
    int   cyc = 0;
    int   start_edge = 0;

    function automatic exp_t mk(input logic li, input logic iv, input int r,
                                input logic ws, input logic ad, input int b,
                                input logic bz, input logic dn);
        exp_t e;
        e.load_init = li;
        e.iv_sel    = iv;
        e.round     = r[5:0];
        e.w_sel     = ws;
        e.add_en    = ad;
        e.blk       = b[1:0];
        e.busy      = bz;
        e.done      = dn;
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cur = '0;
        end else begin
            cyc++;
            if (cur.busy) begin
                if (abort) begin
                    q.delete();
                    cur = '0;
                end else if (q.size() > 0) begin
                    cur = q.pop_front();
                end else begin
                    cur = '0;
                end
            end else if (start && !abort) begin
                int n;
                n = (num_blocks == 2'd0) ? 1 : int'(num_blocks);
                for (int b = 0; b < n; b++) begin
                    q.push_back(mk(1'b1, b == 0, 0, 1'b0, 1'b0, b, 1'b1, 1'b0));
                    for (int t = 0; t < 64; t++)
                        q.push_back(mk(1'b0, 1'b0, t, t >= 16, 1'b0, b, 1'b1, 1'b0));
                    q.push_back(mk(1'b0, 1'b0, 63, 1'b0, 1'b1, b, 1'b1, 1'b0));
                end
                q.push_back(mk(1'b0, 1'b0, 63, 1'b0, 1'b0, n - 1, 1'b1, 1'b1));
                cur = q.pop_front();
                start_edge = cyc;
            end else begin
                cur = '0;
            end
        end
    end

    int n_add = 0, n_load = 0, n_iv = 0, n_w = 0, n_done = 0, done_lat = 0;

    always @(negedge clk) begin
        total++;
        if (dut_vec !== cur) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, dut_vec, cur);
        end
        if (add_en)    n_add++;
        if (load_init) n_load++;
        if (iv_sel)    n_iv++;
        if (w_sel)     n_w++;
        if (done) begin
            n_done++;
            done_lat = cyc - start_edge;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_done(input string nm, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check(nm, int'(seen), 1);
    endtask

    task automatic run_hash(input logic [1:0] nb, input int exp_lat, input int nblk);
        int  a0, l0, i0, w0;
        bit  seen;
        a0 = n_add; l0 = n_load; i0 = n_iv; w0 = n_w;
        start = 1'b1;
        num_blocks = nb;
        tick();
        start = 1'b0;
        num_blocks = 2'd3;
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("done_seen", seen);
        check("latency", done_lat, exp_lat);
        check("add_en_count", n_add - a0, nblk);
        check("load_init_count", n_load - l0, nblk);
        check("iv_sel_count", n_iv - i0, 1);
        check("w_sel_count", n_w - w0, 48 * nblk);
        tick();
        check("busy_after_done", int'(busy), 0);
        tick();
    endtask

    task automatic wait_round(input int r);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            if (busy && !load_init && !add_en && round_idx == r[5:0]) hit = 1'b1;
        end
        check("round_reached", int'(hit), 1);
    endtask

    initial begin
        int  a0, d0, k;
        bit  seen;

        repeat (3) tick();
        check("reset_outputs", int'(dut_vec), 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", int'(busy), 0);

        run_hash(2'd1, 66, 1);
        run_hash(2'd2, 132, 2);
        run_hash(2'd0, 66, 1);
        run_hash(2'd3, 198, 3);

        // abort at round 30
        start = 1'b1; num_blocks = 2'd1;
        tick();
        start = 1'b0;
        wait_round(30);
        a0 = n_add; d0 = n_done;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_outputs", int'(dut_vec), 0);
        repeat (80) tick();
        check("abort_no_add", n_add - a0, 0);
        check("abort_no_done", n_done - d0, 0);
        run_hash(2'd1, 66, 1);

        // start together with abort while idle
        start = 1'b1; abort = 1'b1;
        tick();
        check("start_abort_idle", int'(busy), 0);
        start = 1'b0; abort = 1'b0;
        tick();
        check("start_abort_idle2", int'(busy), 0);

        // asynchronous reset at round 40
        start = 1'b1; num_blocks = 2'd2;
        tick();
        start = 1'b0;
        wait_round(40);
        a0 = n_add; d0 = n_done;
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", int'(dut_vec), 0);
        tick();
        rst_n = 1'b1;
        repeat (300) tick();
        check("reset_no_add", n_add - a0, 0);
        check("reset_no_done", n_done - d0, 0);
        check("reset_idle", int'(busy), 0);

        // start held high: back-to-back hashes
        d0 = n_done;
        start = 1'b1; num_blocks = 2'd1;
        wait_done("held_done1", seen);
        k = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            k++;
            if (load_init) seen = 1'b1;
        end
        check("held_gap", k, 2);
        start = 1'b0;
        wait_done("held_done2", seen);
        check("held_latency", done_lat, 66);
        check("held_done_count", n_done - d0, 2);
        tick();
        check("held_end_idle", int'(busy), 0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
